// File: rtl/frame_stream_arbiter.sv
// frame_stream_arbiter: merges two framed 32-bit sources into one stream.
// Grants are frame-atomic. Contention is resolved by a 1-bit round-robin pointer.
// The output register adds one cycle of latency and sustains one beat per cycle.
// Optional build macro FRAME_ARB_TIMEOUT_EN adds a mid-frame stall watchdog.
// On expiry the watchdog closes the frame with a 32'hDEAD000X marker beat.
module frame_stream_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s0_data,
  input  logic        s0_valid,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic [31:0] s1_data,
  input  logic        s1_valid,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic [7:0]  abort_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic [31:0] m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic [15:0] frame_cnt0_q, frame_cnt0_d;
  logic [15:0] frame_cnt1_q, frame_cnt1_d;

  logic        granted_s;
  logic        src_s;
  logic        g_valid_s;
  logic        g_last_s;
  logic [31:0] g_data_s;
  logic        out_free_s;
  logic        accept_s;
  logic        abort_s;

  // The granted source is multiplexed once so both grant states share one datapath.
  assign granted_s  = (state_q == GRANT0) || (state_q == GRANT1);
  assign src_s      = (state_q == GRANT1);
  assign g_valid_s  = src_s ? s1_valid : s0_valid;
  assign g_last_s   = src_s ? s1_last  : s0_last;
  assign g_data_s   = src_s ? s1_data  : s0_data;
  assign out_free_s = !m_tvalid_q || m_tready;
  assign accept_s   = granted_s && g_valid_s && out_free_s;

  // Ready follows the output register's room, so a stalled sink stalls the source in the same cycle.
  assign s0_ready = (state_q == GRANT0) && out_free_s;
  assign s1_ready = (state_q == GRANT1) && out_free_s;

`ifdef FRAME_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]      abort_cnt_q, abort_cnt_d;

  // An abort needs the output register free so the marker beat never overwrites pending data.
  assign abort_s = granted_s && !g_valid_s && out_free_s && (idle_cnt_q == TO_LIMIT);

  // Watchdog next state: count stalled grant cycles, saturate the abort counter.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (!granted_s || accept_s) begin
      idle_cnt_d = {TO_W{1'b0}};
    end else if (!g_valid_s && (idle_cnt_q != TO_LIMIT)) begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    if (abort_s && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end else begin
      abort_cnt_d = abort_cnt_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q  <= {TO_W{1'b0}};
      abort_cnt_q <= 8'd0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt = abort_cnt_q;
`else
  assign abort_s   = 1'b0;
  assign abort_cnt = 8'd0;

  // TIMEOUT_CYCLES only matters to the watchdog; referencing it here keeps one parameter list for both builds.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

  // Arbitration, output register load/drain and per-source frame counting.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    m_tvalid_d   = m_tvalid_q && !m_tready;
    frame_cnt0_d = frame_cnt0_q;
    frame_cnt1_d = frame_cnt1_q;
    case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) begin
          state_d = rr_q ? GRANT1 : GRANT0;
        end else if (s0_valid) begin
          state_d = GRANT0;
        end else if (s1_valid) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (accept_s) begin
          m_tdata_d  = g_data_s;
          m_tlast_d  = g_last_s;
          m_tvalid_d = 1'b1;
          if (g_last_s) begin
            state_d = IDLE;
            rr_d    = ~src_s;
            if (src_s) begin
              frame_cnt1_d = frame_cnt1_q + 16'd1;
            end else begin
              frame_cnt0_d = frame_cnt0_q + 16'd1;
            end
          end else begin
            state_d = state_q;
          end
        end else if (abort_s) begin
          m_tdata_d  = {16'hDEAD, 15'd0, src_s};
          m_tlast_d  = 1'b1;
          m_tvalid_d = 1'b1;
          rr_d       = ~rr_q;
          state_d    = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, output register and frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      m_tdata_q    <= 32'd0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      frame_cnt0_q <= 16'd0;
      frame_cnt1_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      frame_cnt0_q <= frame_cnt0_d;
      frame_cnt1_q <= frame_cnt1_d;
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign frame_cnt0 = frame_cnt0_q;
  assign frame_cnt1 = frame_cnt1_q;

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Testbench for frame_stream_arbiter.
// It uses directed scenarios and a randomized alternation scenario.
// The expected order comes from a frame-level queue model.
module tb_frame_stream_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s0_data = 32'd0, s1_data = 32'd0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_last = 1'b0, s1_last = 1'b0;
  logic        s0_ready, s1_ready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [15:0] frame_cnt0, frame_cnt1;
  logic [7:0]  abort_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] fdat [2][16][4];
  int          flen [2][16];

  always #5 clk = ~clk;

  frame_stream_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .abort_cnt(abort_cnt)
  );

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = 32'd0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = 32'd0;
    m_tready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1; s0_data = $urandom; s1_data = $urandom;
    m_tready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if ({m_tvalid, m_tlast} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got valid/last %b, expected 00", {m_tvalid, m_tlast}); end
    n_checks++; if (m_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_tdata: got %h, expected 0", m_tdata); end
    n_checks++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b, expected 00", {s0_ready, s1_ready}); end
    n_checks++; if ({frame_cnt0, frame_cnt1, abort_cnt} !== 40'd0) begin n_fail++; $display("FAIL reset_counters: got %h %h %h, expected 0 0 0", frame_cnt0, frame_cnt1, abort_cnt); end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_frame();
    logic [31:0] a [3];
    for (int i = 0; i < 3; i++) a[i] = $urandom;
    do_reset();
    s0_valid = 1'b1; s0_data = a[0]; s0_last = 1'b0;
    #4;
    n_checks++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL single_idle_ready: got %b, expected 0", s0_ready); end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s0_data = a[i]; s0_last = (i == 2);
      #4;
      n_checks++; if (s0_ready !== 1'b1) begin n_fail++; $display("FAIL single_grant_ready beat %0d: got %b, expected 1", i, s0_ready); end
      @(posedge clk); #1;
      n_checks++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, (i == 2), a[i]}) begin
        n_fail++; $display("FAIL single_beat %0d: got v=%b l=%b d=%h, expected v=1 l=%b d=%h", i, m_tvalid, m_tlast, m_tdata, (i == 2), a[i]);
      end
    end
    @(negedge clk);
    s0_valid = 1'b0; s0_last = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got m_tvalid %b, expected 0", m_tvalid); end
    n_checks++; if (frame_cnt0 !== 16'd1) begin n_fail++; $display("FAIL single_cnt0: got %0d, expected 1", frame_cnt0); end
  endtask

  // Frames alternate strictly while both sources have traffic: s0 frame k, then s1 frame k.
  task automatic run_alternation(input int nf0, input int nf1, input bit rnd, input string tag);
    logic [32:0] expq [$];
    logic [32:0] e;
    int nf [2];
    int fi [2];
    int bi [2];
    int gapc [2];
    logic v [2];
    logic l [2];
    logic [31:0] d [2];
    logic rdy;
    bit gap;
    int cyc;
    nf[0] = nf0; nf[1] = nf1;
    for (int i = 0; i < 2; i++) begin
      fi[i] = 0; bi[i] = 0; gapc[i] = 0;
      for (int k = 0; k < 16; k++) begin
        flen[i][k] = rnd ? int'($urandom_range(1, 4)) : 2;
        for (int b = 0; b < 4; b++) fdat[i][k][b] = {8'(i + 1), 8'(k), 8'(b), 8'($urandom)};
      end
    end
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 2; i++)
        if (k < nf[i])
          for (int b = 0; b < flen[i][k]; b++) expq.push_back({(b == flen[i][k] - 1), fdat[i][k][b]});
    cyc = 0;
    while (expq.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      reset = (cyc < 2);
      for (int i = 0; i < 2; i++) begin
        if (fi[i] < nf[i]) begin
          gap = rnd && (bi[i] > 0) && (gapc[i] < 3) && ($urandom_range(0, 3) == 0);
          gapc[i] = gap ? gapc[i] + 1 : 0;
          v[i] = !gap;
          d[i] = fdat[i][fi[i]][bi[i]];
          l[i] = (bi[i] == flen[i][fi[i]] - 1);
        end else begin
          v[i] = 1'b0; d[i] = 32'd0; l[i] = 1'b0;
        end
      end
      s0_valid = v[0]; s0_data = d[0]; s0_last = l[0];
      s1_valid = v[1]; s1_data = d[1]; s1_last = l[1];
      m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #4;
      if (!reset) begin
        n_checks++;
        if (s0_ready && s1_ready) begin n_fail++; $display("FAIL %s ready_exclusive: got s0_ready=%b s1_ready=%b, expected at most one", tag, s0_ready, s1_ready); end
        if (m_tvalid && m_tready) begin
          n_checks++;
          if (expq.size() == 0) begin
            n_fail++; $display("FAIL %s extra_beat: got d=%h, expected no further beat", tag, m_tdata);
          end else begin
            e = expq.pop_front();
            if ({m_tlast, m_tdata} !== e) begin
              n_fail++; $display("FAIL %s out_beat: got l=%b d=%h, expected l=%b d=%h", tag, m_tlast, m_tdata, e[32], e[31:0]);
            end
          end
        end
        for (int i = 0; i < 2; i++) begin
          rdy = (i == 0) ? s0_ready : s1_ready;
          if (v[i] && rdy) begin
            if (l[i]) begin fi[i]++; bi[i] = 0; end
            else bi[i]++;
          end
        end
      end
      @(posedge clk);
      cyc++;
    end
    n_checks++; if (expq.size() != 0) begin n_fail++; $display("FAIL %s stream_budget: got %0d beats outstanding, expected 0", tag, expq.size()); end
    @(negedge clk);
    idle_inputs();
    n_checks++; if (frame_cnt0 !== 16'(nf0)) begin n_fail++; $display("FAIL %s cnt0: got %0d, expected %0d", tag, frame_cnt0, nf0); end
    n_checks++; if (frame_cnt1 !== 16'(nf1)) begin n_fail++; $display("FAIL %s cnt1: got %0d, expected %0d", tag, frame_cnt1, nf1); end
  endtask

  task automatic test_contention();
    run_alternation(2, 1, 1'b0, "contention");
  endtask

  task automatic test_random_alternation();
    run_alternation(12, 12, 1'b1, "random");
  endtask

  task automatic test_backpressure();
    logic [31:0] b [4];
    int got, bi, stall;
    bit stall_done;
    for (int i = 0; i < 4; i++) b[i] = $urandom;
    do_reset();
    got = 0; bi = 0; stall = 0; stall_done = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      s0_valid = (bi < 4); s0_data = b[(bi < 4) ? bi : 0]; s0_last = (bi == 3);
      if (got == 2 && !stall_done && stall == 0) stall = 5;
      m_tready = (stall == 0);
      #4;
      if (stall > 0) begin
        n_checks++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, expected 0", s0_ready); end
        n_checks++; if ({m_tvalid, m_tdata} !== {1'b1, b[got]}) begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h, expected v=1 d=%h", m_tvalid, m_tdata, b[got]); end
        stall--;
        if (stall == 0) stall_done = 1'b1;
      end else if (m_tvalid) begin
        n_checks++;
        if ({m_tlast, m_tdata} !== {(got == 3), b[got]}) begin n_fail++; $display("FAIL bp_beat %0d: got l=%b d=%h, expected l=%b d=%h", got, m_tlast, m_tdata, (got == 3), b[got]); end
        got++;
      end
      if (s0_valid && s0_ready) bi++;
      @(posedge clk);
    end
    n_checks++; if (got != 4 || !stall_done) begin n_fail++; $display("FAIL bp_budget: got %0d beats, expected 4", got); end
    @(negedge clk);
    idle_inputs();
    n_checks++; if (frame_cnt0 !== 16'd1) begin n_fail++; $display("FAIL bp_cnt0: got %0d, expected 1", frame_cnt0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d [4];
    logic [31:0] c, e;
    int got, bi;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    c = $urandom; e = $urandom;
    do_reset();
    got = 0; bi = 0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      @(negedge clk);
      s0_valid = 1'b1; s0_data = d[bi]; s0_last = (bi == 3);
      #4;
      if (m_tvalid && m_tready) got++;
      if (s0_valid && s0_ready) bi++;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    s0_data = d[bi]; s0_last = (bi == 3);
    @(posedge clk); #1;
    n_checks++; if ({m_tvalid, m_tlast} !== 2'b00) begin n_fail++; $display("FAIL rmid_flags: got v/l %b, expected 00", {m_tvalid, m_tlast}); end
    n_checks++; if (m_tdata !== 32'd0) begin n_fail++; $display("FAIL rmid_tdata: got %h, expected 0", m_tdata); end
    n_checks++; if ({frame_cnt0, frame_cnt1, abort_cnt} !== 40'd0) begin n_fail++; $display("FAIL rmid_counters: got %h %h %h, expected 0 0 0", frame_cnt0, frame_cnt1, abort_cnt); end
    @(negedge clk);
    reset = 1'b0;
    s0_valid = 1'b1; s0_data = c; s0_last = 1'b1;
    s1_valid = 1'b1; s1_data = e; s1_last = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    n_checks++; if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, c}) begin n_fail++; $display("FAIL rmid_restart: got v=%b l=%b d=%h, expected v=1 l=1 d=%h", m_tvalid, m_tlast, m_tdata, c); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [31:0] e, f;
    int idle;
    bit seen;
    e = $urandom; f = $urandom;
    do_reset();
    s1_valid = 1'b1; s1_data = e; s1_last = 1'b0;
    @(posedge clk);
    @(negedge clk); #4;
    n_checks++; if (s1_ready !== 1'b1) begin n_fail++; $display("FAIL to_grant: got s1_ready %b, expected 1", s1_ready); end
    @(posedge clk); #1;
    n_checks++; if ({m_tvalid, m_tdata} !== {1'b1, e}) begin n_fail++; $display("FAIL to_first_beat: got v=%b d=%h, expected v=1 d=%h", m_tvalid, m_tdata, e); end
    @(negedge clk);
    s1_valid = 1'b0;
    idle = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      idle++;
      if (m_tvalid) seen = 1'b1;
    end
`ifdef FRAME_ARB_TIMEOUT_EN
    n_checks++; if (!seen || idle < TO || idle > TO + 2) begin n_fail++; $display("FAIL to_abort_time: got seen=%b after %0d cycles, expected abort after %0d..%0d", seen, idle, TO, TO + 2); end
    n_checks++; if ({m_tlast, m_tdata} !== {1'b1, 32'hDEAD0001}) begin n_fail++; $display("FAIL to_marker: got l=%b d=%h, expected l=1 d=dead0001", m_tlast, m_tdata); end
    n_checks++; if (abort_cnt !== 8'd1) begin n_fail++; $display("FAIL to_abort_cnt: got %0d, expected 1", abort_cnt); end
    n_checks++; if (frame_cnt1 !== 16'd0) begin n_fail++; $display("FAIL to_cnt1_unchanged: got %0d, expected 0", frame_cnt1); end
    n_checks++; if (s1_ready !== 1'b0) begin n_fail++; $display("FAIL to_released: got s1_ready %b, expected 0", s1_ready); end
`else
    n_checks++; if (seen) begin n_fail++; $display("FAIL to_no_abort: got output d=%h, expected no beat", m_tdata); end
    n_checks++; if (abort_cnt !== 8'd0) begin n_fail++; $display("FAIL to_abort_cnt: got %0d, expected 0", abort_cnt); end
    n_checks++; if (s1_ready !== 1'b1) begin n_fail++; $display("FAIL to_grant_held: got s1_ready %b, expected 1", s1_ready); end
`endif
    @(negedge clk);
    s1_valid = 1'b1; s1_data = f; s1_last = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(posedge clk); #1;
      if (m_tvalid) seen = 1'b1;
    end
    n_checks++; if ({seen, m_tlast, m_tdata} !== {2'b11, f}) begin n_fail++; $display("FAIL to_next_frame: got seen=%b l=%b d=%h, expected 1 1 %h", seen, m_tlast, m_tdata, f); end
    n_checks++; if (frame_cnt1 !== 16'd1) begin n_fail++; $display("FAIL to_next_cnt1: got %0d, expected 1", frame_cnt1); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Preloading the counter just below the wrap point reaches 65535 -> 0 with a few real frames.
  task automatic test_counter_wrap();
    logic [15:0] exp_cnt;
    bit hs;
    do_reset();
    force dut.frame_cnt1_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_cnt1_q;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      s1_valid = 1'b1; s1_last = 1'b1; s1_data = $urandom;
      hs = 1'b0;
      for (int c = 0; c < 6 && !hs; c++) begin
        #4;
        hs = s1_ready;
        @(posedge clk); #1;
        if (!hs) @(negedge clk);
      end
      exp_cnt = exp_cnt + 16'd1;
      n_checks++; if (!hs || frame_cnt1 !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt1 frame %0d: got %h (accepted=%b), expected %h", k, frame_cnt1, hs, exp_cnt); end
      @(negedge clk);
      s1_valid = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_frame();
    test_contention();
    test_backpressure();
    test_reset_mid_frame();
    test_timeout();
    test_counter_wrap();
    test_random_alternation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_stream_arbiter.md
FRAME_STREAM_ARBITER -- requirements
Module: frame_stream_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: mid-frame idle cycles on the granted source before the frame is aborted.
REQ-002 SHALL have port clk  input  1: single clock for all logic.
REQ-003 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-004 SHALL have ports s0_data / s0_valid / s0_last  input  32/1/1: source-0 beat, valid and end-of-frame.
REQ-005 SHALL have port s0_ready  output  1: source-0 beat accepted when s0_valid && s0_ready.
REQ-006 SHALL have ports s1_data / s1_valid / s1_last  input  32/1/1, and s1_ready  output  1, identical to source 0.
REQ-007 SHALL have ports m_tdata / m_tvalid / m_tlast  output  32/1/1: merged stream towards the MicroBlaze FIFO.
REQ-008 SHALL have port m_tready  input  1: downstream accepts when m_tvalid && m_tready.
REQ-009 SHALL have ports frame_cnt0 / frame_cnt1  output  16: frames forwarded per source.
REQ-010 SHALL have port abort_cnt  output  8: frames aborted by timeout.

Function
REQ-011 SHALL implement states IDLE, GRANT0 and GRANT1, with a 1-bit round-robin pointer rr.
REQ-012 In IDLE, if exactly one sX_valid is high, the block SHALL move to GRANTX on the next edge.
REQ-013 In IDLE, if both sources are valid, the block SHALL grant source rr.
REQ-014 In IDLE, both sX_ready SHALL be 0.
REQ-015 In GRANTX, sX_ready SHALL equal (!m_tvalid || m_tready), and the other source's ready SHALL be 0.
REQ-016 An accepted beat SHALL load the m_tdata/m_tlast output register on the same edge and set m_tvalid=1: one-cycle latency.
REQ-017 m_tvalid SHALL clear only on m_tready with no new beat loaded, and m_tdata/m_tlast SHALL stay stable while m_tvalid && !m_tready.
REQ-018 Accepting a beat with sX_last=1 SHALL return the block to IDLE, set rr to the other source, and increment frame_cnt X, wrapping 65535 -> 0.
REQ-019 The grant SHALL never change mid-frame: no interleaving of beats from the two sources within a frame.
REQ-020 Simultaneous frame end and new requests SHALL give one IDLE cycle before the next grant, arbitrated by the updated rr.
REQ-021 With continuous traffic from both sources, frames SHALL strictly alternate 0,1,0,1.
REQ-022 Sustained throughput SHALL be one beat per cycle within a frame when m_tready=1.

Reset
REQ-023 On reset, the block SHALL enter IDLE, with rr=0, m_tvalid=0, m_tlast=0, m_tdata=0, s0_ready=s1_ready=0, frame_cnt0=frame_cnt1=0 and abort_cnt=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame and the output register contents, with no m_tlast emitted.
REQ-025 After reset deasserts, the first grant SHALL follow REQ-012/REQ-013.

Configuration
REQ-026 Macro FRAME_ARB_TIMEOUT_EN SHALL enable the mid-frame timeout watchdog.
REQ-027 With FRAME_ARB_TIMEOUT_EN defined, in GRANTX a counter SHALL increment on each cycle with sX_valid=0, and clear on each accepted beat and on entering GRANTX.
REQ-028 With FRAME_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES and the output register is free, the block SHALL load m_tdata=32'hDEAD000X with m_tlast=1.
REQ-029 With FRAME_ARB_TIMEOUT_EN defined, the timeout abort SHALL increment abort_cnt (saturating at 255), toggle rr, and go to IDLE; frame_cnt SHALL not change.
REQ-030 With FRAME_ARB_TIMEOUT_EN defined, later beats from the aborted source SHALL be treated as a new frame.
REQ-031 Without FRAME_ARB_TIMEOUT_EN, no watchdog SHALL exist, abort_cnt SHALL be constant 0, and a stalled source SHALL hold the grant indefinitely.

Verification
REQ-032 Single frame: s0 sends 3 beats A1,A2,A3(last), m_tready=1 -> m_tdata A1,A2,A3 on consecutive cycles, m_tlast only on A3, frame_cnt0=1.
REQ-033 Contention: both sources hold 2-beat frames valid from reset -> output order s0 frame, s1 frame, s0 frame; no interleaved beats.
REQ-034 Backpressure: m_tready=0 for 5 cycles mid-frame -> m_tdata held constant, s0_ready=0 for those cycles, and no beat lost or duplicated.
REQ-035 Reset mid-frame: assert reset after beat 2 of 4 -> next cycle m_tvalid=0, counters=0, and the next frame starts cleanly from source 0.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=16): s1 sends 1 beat then drops valid -> after 16 idle cycles, m_tdata=32'hDEAD0001 with m_tlast=1 and abort_cnt=1; the same stimulus with the macro off keeps the grant with no abort.
REQ-037 Counter wrap: force 65536 single-beat frames on s1 -> frame_cnt1 returns to 0.
